// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a 4:1 shared-resource mux: one-hot grant, registered select, release on done.
// Optional watchdog force-release is compiled in with `define ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 busy,
  output logic                 timeout
);

  if (SEL_WIDTH != $clog2(NUM_REQ) || MAX_CYCLES < 2) begin : g_bad_cfg
    $error("rr_mux_arbiter: inconsistent SEL_WIDTH/NUM_REQ or MAX_CYCLES < 2");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [SEL_WIDTH-1:0] winner;
  logic                 releaseOwn;
  logic                 forceOwn;

  // First asserted request scanning from ptr upward; index arithmetic wraps since NUM_REQ is a power of two.
  always_comb begin
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + k[SEL_WIDTH-1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign releaseOwn = done || !req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero while idle, so the first owned cycle sees 0.
  assign cnt_d    = (state_q == OWN) ? cnt_q + 1'b1 : '0;
  assign forceOwn = (state_q == OWN) && !releaseOwn && (cnt_q == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign forceOwn = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = OWN;
      OWN:     if (releaseOwn || forceOwn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner's index doubles as sel, so the pointer advance reads sel_q directly.
  always_comb begin
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = NUM_REQ'(1) << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
        end
      end
      OWN: begin
        if (releaseOwn || forceOwn) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = sel_q + 1'b1;
          timeout_d = forceOwn;
        end
      end
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4-way datapath resource among NUM_REQ requesters.
- The shared resource is a memory port, a write-back bus or a result bus behind a 4:1 multiplexer.
- Owns the multiplexer select and issues a one-hot grant.
- Holds ownership until the resource signals completion, then rotates priority.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 to match the 4-input mux.
- SEL_WIDTH, 2, width of the mux select; must equal clog2(NUM_REQ).
- MAX_CYCLES, 16, watchdog limit in cycles for one grant; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request per requester; level, held until granted and served.
- done  input  1  one-cycle pulse from the shared resource: current transfer finished.
- grant  output  NUM_REQ  one-hot grant, registered.
- sel  output  SEL_WIDTH  mux select = index of current/last owner, registered.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when the watchdog forces release (0 without macro).

Behaviour:
- Reset (async, immediate, mid-transfer included):
  - state=IDLE, grant=0, sel=0, busy=0, timeout=0, ptr=0, cycle counter=0.
- States: IDLE, OWN.
- IDLE:
  - If req!=0 at a rising edge, pick the first asserted bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - At that same edge: grant=onehot(winner), sel=winner, busy=1, state->OWN.
  - Latency: req sampled high at edge k -> grant high after edge k (1 cycle).
  - req==0: stay IDLE; sel holds last owner.
- OWN:
  - done=1 at edge: grant=0, busy=0, ptr=(winner+1) mod NUM_REQ, state->IDLE.
  - Owner's req=0 with done=0 (abandon): same as done; release and advance ptr.
  - done and req drop together: treated as one release.
  - Requests from non-owners: ignored, no preemption.
  - Minimum idle gap between grants is exactly 1 cycle (the IDLE cycle), even with requests pending.
- Fairness:
  - ptr wraps 3->0.
  - With all 4 requesters continuously requesting, grant order is 0,1,2,3,0,...
- Illegal and ignored inputs:
  - done in IDLE: ignored; no state change.
  - grant never has more than one bit set; grant==0 in IDLE.
- sel changes only on the grant edge, never during OWN.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to OWN and increments each OWN cycle.
  - If it reaches MAX_CYCLES-1 with no done, the next edge force-releases: grant=0, busy=0, ptr advances, state->IDLE.
  - timeout pulses high for exactly one cycle after that edge.
  - done on the limit cycle takes priority: normal release, no timeout.
- Undefined:
  - No counter; timeout tied 0.
  - An owner may hold the resource indefinitely.

Test Plan:
- Reset: assert rst mid-OWN with grant=0100 -> grant=0000, sel=0, busy=0 immediately, no clock needed; after release req=0001 -> grant=0001 after 1 edge.
- Single requester: req=0010 -> grant=0010, sel=1, busy=1 after 1 edge; done pulse -> grant=0000 next edge; ptr=2.
- Round-robin: req=1111 held, done pulse 2 cycles after each grant -> grants 0001,0010,0100,1000,0001, one idle cycle between each.
- Wrap and skip: ptr=3, req=0101 -> grant=0001 (index 0), then ptr=1 -> next grant=0100.
- Abandon and stray done: owner 2 drops req without done -> release, ptr=3; done pulse while IDLE -> no change.
- ARB_TIMEOUT_EN with MAX_CYCLES=16: owner 1 never signals done -> grant drops and timeout pulses once, 16 cycles after grant; done on cycle 16 instead -> no timeout.
